// File: rtl/rom_read_arbiter.sv
// Round-robin read arbiter/sequencer in front of a shared synchronous ROM.
// Latency: request sampled to rsp_valid in 3 cycles; a single read turns around in 3 cycles.
// Backpressure: none on responses; a requester holds req until it sees its gnt bit.
//
// Ports:
//   clk, reset            - clock, async active-high reset
//   req / req_addr        - per-requester read request and packed address
//   req_burst             - burst qualifier (only when ROM_ARB_BURST_EN is defined)
//   gnt                   - one-hot, one-cycle grant pulse
//   rsp_valid / rsp_data / rsp_last - returned word, owner one-hot, final-beat flag
//   rom_en / rom_addr / rom_data    - ROM macro interface (data one cycle after address)
//   busy                  - transaction in flight, grant through final response
//
// Optional feature: define ROM_ARB_BURST_EN for BURST_LEN-beat wrapping bursts.
module rom_read_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
`ifdef ROM_ARB_BURST_EN
  input  logic [NUM_REQ-1:0]        req_burst,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      busy
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state, state_d;
  logic [OWN_W-1:0]   last_winner, last_winner_d;
  logic [OWN_W-1:0]   owner, owner_d;
  logic [OWN_W-1:0]   win;
  logic               found;
  logic [ADDR_W-1:0]  win_addr;
  logic [NUM_REQ-1:0] gnt_d;
  logic               rom_en_d;
  logic [ADDR_W-1:0]  rom_addr_d;
  logic               busy_d;
  logic               beat_last;

  // Return pipe: stage 0 lines up with ROM output, stage 1 with rsp_data.
  logic               p0_vld, p0_last, p1_vld, p1_last;
  logic [OWN_W-1:0]   p0_owner, p1_owner;

`ifdef ROM_ARB_BURST_EN
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic             burst, burst_d;
  logic [CNT_W-1:0] beat, beat_d;
  assign beat_last = !burst || (beat == CNT_W'(BURST_LEN - 1));
`else
  assign beat_last = 1'b1;
`endif

  // Round-robin search starting just above the previous winner.
  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_winner) + k) % NUM_REQ;
      if (!found && req[OWN_W'(idx)]) begin
        found = 1'b1;
        win   = OWN_W'(idx);
      end
    end
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OWN_W'(i) == win) win_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_d       = state;
    gnt_d         = '0;
    rom_en_d      = rom_en;
    rom_addr_d    = rom_addr;
    owner_d       = owner;
    last_winner_d = last_winner;
    busy_d        = busy;
`ifdef ROM_ARB_BURST_EN
    burst_d       = burst;
    beat_d        = beat;
`endif
    // Final beat at the tail this cycle: busy drops next cycle unless a
    // new grant is made on the same edge.
    if (p1_vld && p1_last) busy_d = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_d[win]    = 1'b1;
          rom_en_d      = 1'b1;
          rom_addr_d    = win_addr;
          owner_d       = win;
          last_winner_d = win;
          busy_d        = 1'b1;
          state_d       = ISSUE;
`ifdef ROM_ARB_BURST_EN
          burst_d       = req_burst[win];
          beat_d        = '0;
`endif
        end
      end
      ISSUE: begin
        if (beat_last) begin
          rom_en_d = 1'b0;
          state_d  = DRAIN;
        end else begin
          rom_addr_d = rom_addr + 1'b1;  // wraps naturally at 2^ADDR_W
`ifdef ROM_ARB_BURST_EN
          beat_d     = beat + 1'b1;
`endif
        end
      end
      DRAIN: begin
        // Leave as the final beat moves to the tail so that the rsp_last
        // cycle is already an arbitration cycle.
        if (p0_vld && p0_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt         <= '0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      busy        <= 1'b0;
      owner       <= '0;
      last_winner <= OWN_W'(NUM_REQ - 1);
      p0_vld      <= 1'b0;
      p0_last     <= 1'b0;
      p0_owner    <= '0;
      p1_vld      <= 1'b0;
      p1_last     <= 1'b0;
      p1_owner    <= '0;
      rsp_data    <= '0;
    end else begin
      gnt         <= gnt_d;
      rom_en      <= rom_en_d;
      rom_addr    <= rom_addr_d;
      busy        <= busy_d;
      owner       <= owner_d;
      last_winner <= last_winner_d;
      p0_vld      <= rom_en;
      p0_last     <= beat_last;
      p0_owner    <= owner;
      p1_vld      <= p0_vld;
      p1_last     <= p0_last;
      p1_owner    <= p0_owner;
      if (p0_vld) rsp_data <= rom_data;
    end
  end

`ifdef ROM_ARB_BURST_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst <= 1'b0;
      beat  <= '0;
    end else begin
      burst <= burst_d;
      beat  <= beat_d;
    end
  end
`endif

  assign rsp_valid = p1_vld ? (NUM_REQ'(1) << p1_owner) : '0;
  assign rsp_last  = p1_vld & p1_last;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a response scoreboard.
module tb_rom_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [23:0] req_addr;
  logic [3:0]  req_burst;
  logic [3:0]  gnt, rsp_valid;
  logic [7:0]  rsp_data, rom_data;
  logic        rsp_last, rom_en, busy;
  logic [5:0]  rom_addr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] vld;
    logic [7:0] dat;
    logic       last;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  logic [7:0] rom_mem [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_read_arbiter #(.NUM_REQ(4), .ADDR_W(6), .DATA_W(8), .BURST_LEN(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_addr(req_addr),
`ifdef ROM_ARB_BURST_EN
    .req_burst(req_burst),
`endif
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_last(rsp_last),
    .rom_en(rom_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .busy(busy)
  );

  // Synchronous ROM, rom[i] = i.
  initial for (int i = 0; i < 64; i++) rom_mem[i] = 8'(i);
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic void push(input int r, input int d, input bit l);
    exp_t e;
    e.vld  = 4'(1 << r);
    e.dat  = 8'(d);
    e.last = l;
    sbq.push_back(e);
  endfunction

  task automatic set_addr(input int i, input logic [5:0] a);
    req_addr[i*6 +: 6] = a;
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 20 && g == 4'd0; i++) begin
      @(negedge clk);
      g = gnt;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   gnt, 0);
    chk({tag, "_vld"},   rsp_valid, 0);
    chk({tag, "_data"},  rsp_data, 0);
    chk({tag, "_last"},  rsp_last, 0);
    chk({tag, "_romen"}, rom_en, 0);
    chk({tag, "_addr"},  rom_addr, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  // Scoreboard: every returned word must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rsp_valid != 4'd0) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_valid", rsp_valid, mon_e.vld);
        chk("sb_data",  rsp_data,  mon_e.dat);
        chk("sb_last",  rsp_last,  mon_e.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    int prev;
    int exp_w [8];
    reset = 1'b1; req = '0; req_addr = '0; req_burst = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Single read: requester 2, address 32.
    @(negedge clk);
    set_addr(2, 6'd32); req = 4'b0100; push(2, 32, 1);
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_romen", rom_en, 1);
    chk("single_addr", rom_addr, 32);
    chk("single_busy0", busy, 1);
    req = '0;
    @(negedge clk);
    chk("single_gnt_drop", gnt, 0);
    chk("single_busy1", busy, 1);
    chk("single_early_vld", rsp_valid, 0);
    @(negedge clk);
    chk("single_vld", rsp_valid, 4'b0100);
    chk("single_last", rsp_last, 1);
    chk("single_busy2", busy, 1);
    @(negedge clk);
    chk("single_busy_off", busy, 0);
    chk("single_vld_off", rsp_valid, 0);

    // Contention: all four at once, served 0..3, 3 cycles apart.
    do_reset();
    set_addr(0, 6'd39); set_addr(1, 6'd42); set_addr(2, 6'd50); set_addr(3, 6'd61);
    req = 4'b1111;
    push(0, 39, 1); push(1, 42, 1); push(2, 50, 1); push(3, 61, 1);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      chk("cont_gnt", g, 32'(1 << k));
      if (k > 0) chk("cont_gap", 32'(cyc - prev), 3);
      prev = cyc;
      req[k] = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("cont_drain", 32'(sbq.size()), 0);

    // Fairness: 0 and 3 held; 1 joins after the fourth grant.
    do_reset();
    set_addr(0, 6'd5); set_addr(1, 6'd17); set_addr(3, 6'd9);
    exp_w = '{0, 3, 0, 3, 0, 1, 3, 0};
    req = 4'b1001;
    for (int k = 0; k < 8; k++)
      push(exp_w[k], (exp_w[k] == 0) ? 5 : (exp_w[k] == 1) ? 17 : 9, 1);
    for (int k = 0; k < 8; k++) begin
      wait_gnt(g);
      chk("fair_gnt", g, 32'(1 << exp_w[k]));
      if (k == 3) req[1] = 1'b1;
      if (g == 4'b0010) req[1] = 1'b0;
      if (k == 7) req = '0;
    end
    repeat (4) @(negedge clk);
    chk("fair_drain", 32'(sbq.size()), 0);

    // Wrap test: requester 1 at address 62.
    do_reset();
    set_addr(1, 6'd62); req = 4'b0010;
`ifdef ROM_ARB_BURST_EN
    req_burst = 4'b0010;
    push(1, 62, 0); push(1, 63, 0); push(1, 0, 0); push(1, 1, 1);
`else
    push(1, 62, 1);
`endif
    @(negedge clk);
    chk("wrap_gnt", gnt, 4'b0010);
    req = '0; req_burst = '0;
    @(negedge clk);
    chk("wrap_gnt_pulse", gnt, 0);
    @(negedge clk);
`ifdef ROM_ARB_BURST_EN
    for (int b = 0; b < 4; b++) begin
      chk("wrap_beat_vld", rsp_valid, 4'b0010);
      @(negedge clk);
    end
`else
    chk("wrap_single_vld", rsp_valid, 4'b0010);
    @(negedge clk);
`endif
    chk("wrap_vld_end", rsp_valid, 0);
    chk("wrap_busy_end", busy, 0);
    chk("wrap_drain", 32'(sbq.size()), 0);

    // Reset in the middle of the same transaction.
    do_reset();
    req = 4'b0010;
`ifdef ROM_ARB_BURST_EN
    req_burst = 4'b0010;
    push(1, 62, 0); push(1, 63, 0); push(1, 0, 0); push(1, 1, 1);
`else
    push(1, 62, 1);
`endif
    @(negedge clk);
    req = '0; req_burst = '0;
    @(negedge clk);
`ifdef ROM_ARB_BURST_EN
    repeat (2) @(negedge clk);
`endif
    #2 reset = 1'b1;
    #1 chk_all_zero("midrst");
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", rsp_valid, 0);
    end
    set_addr(0, 6'd7); set_addr(1, 6'd8);
    req = 4'b0011;
    push(0, 7, 1); push(1, 8, 1);
    wait_gnt(g);
    chk("post_rst_gnt0", g, 4'b0001);
    req[0] = 1'b0;
    wait_gnt(g);
    chk("post_rst_gnt1", g, 4'b0010);
    req[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_drain", 32'(sbq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
